// File: rtl/vend_select_ctrl.sv
// Vending selection controller: cursor, credit, price check, dispense and change.
// Optional dispense-ack timeout with refund is compiled in by VEND_TIMEOUT_EN.
module vend_select_ctrl #(
    parameter int NUM_ITEMS      = 8,
    parameter int DENY_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       fastClk,
    input  logic       rstN,
    input  logic       leftSignal,
    input  logic       rightSignal,
    input  logic       selectSignal,
    input  logic       coinValid,
    input  logic [7:0] coinValue,
    input  logic [7:0] priceIn,
    input  logic       dispenseAck,
    output logic [2:0] itemIdx,
    output logic [7:0] credit,
    output logic       dispenseReq,
    output logic [2:0] dispenseItem,
    output logic       changeValid,
    output logic [7:0] changeAmount,
    output logic       denyFlag,
    output logic       busy
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_ITEMS - 1);
    localparam int DW = (DENY_CYCLES > 1) ? $clog2(DENY_CYCLES) : 1;
    localparam logic [DW-1:0] DENY_LAST = DW'(DENY_CYCLES - 1);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 8 || DENY_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("vend_select_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DENY,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_itemIdx;
    logic [7:0]      r_credit;
    logic            r_dispenseReq;
    logic [2:0]      r_dispenseItem;
    logic            r_changeValid;
    logic [7:0]      r_changeAmount;
    logic            r_denyFlag;
    logic            r_busy;
    logic            r_selPrev;
    logic [DW-1:0]   r_denyCnt;

    logic [7:0]      w_coin;
    logic [7:0]      w_creditCoin;
    logic [7:0]      w_remainCoin;
    logic            w_selEvt;
    logic            w_afford;

    function automatic logic [7:0] f_sat(input logic [9:0] s);
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

    assign w_coin       = coinValid ? coinValue : 8'd0;
    assign w_selEvt     = selectSignal && !r_selPrev;
    assign w_afford     = (r_credit >= priceIn);
    assign w_creditCoin = f_sat({2'b00, r_credit} + {2'b00, w_coin});
    // A coin landing in CHECK is added on top of the post-purchase balance
    assign w_remainCoin = f_sat({2'b00, r_credit - priceIn} + {2'b00, w_coin});

`ifdef VEND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]   r_toCnt;
    logic [7:0]      r_price;
    logic [7:0]      w_refund;

    assign w_refund = f_sat({2'b00, r_credit} + {2'b00, r_price} + {2'b00, w_coin});
`endif

    always_ff @(posedge fastClk) begin
        if (!rstN) begin
            r_state        <= S_IDLE;
            r_itemIdx      <= 3'd0;
            r_credit       <= 8'd0;
            r_dispenseReq  <= 1'b0;
            r_dispenseItem <= 3'd0;
            r_changeValid  <= 1'b0;
            r_changeAmount <= 8'd0;
            r_denyFlag     <= 1'b0;
            r_busy         <= 1'b0;
            r_selPrev      <= 1'b0;
            r_denyCnt      <= '0;
`ifdef VEND_TIMEOUT_EN
            r_toCnt        <= '0;
            r_price        <= 8'd0;
`endif
        end else begin
            r_selPrev     <= selectSignal;
            r_changeValid <= 1'b0;
            r_credit      <= w_creditCoin;
            unique case (r_state)
                S_IDLE: begin
                    if (w_selEvt) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                    end else if (rightSignal && !leftSignal) begin
                        r_itemIdx <= (r_itemIdx == LAST_IDX) ? 3'd0 : r_itemIdx + 3'd1;
                    end else if (leftSignal && !rightSignal) begin
                        r_itemIdx <= (r_itemIdx == 3'd0) ? LAST_IDX : r_itemIdx - 3'd1;
                    end
                end
                S_CHECK: begin
                    if (w_afford) begin
                        r_credit       <= w_remainCoin;
                        r_dispenseItem <= r_itemIdx;
                        r_dispenseReq  <= 1'b1;
                        r_state        <= S_DISPENSE;
`ifdef VEND_TIMEOUT_EN
                        r_price        <= priceIn;
                        r_toCnt        <= '0;
`endif
                    end else begin
                        r_denyFlag <= 1'b1;
                        r_denyCnt  <= '0;
                        r_state    <= S_DENY;
                    end
                end
                S_DENY: begin
                    if (r_denyCnt == DENY_LAST) begin
                        r_denyFlag <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_denyCnt <= r_denyCnt + 1'b1;
                    end
                end
                S_DISPENSE: begin
                    if (dispenseAck) begin
                        r_dispenseReq <= 1'b0;
                        if (r_credit != 8'd0) begin
                            r_changeValid  <= 1'b1;
                            r_changeAmount <= w_creditCoin;
                            r_state        <= S_CHANGE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (r_toCnt == TO_LAST) begin
                        r_dispenseReq  <= 1'b0;
                        r_credit       <= w_refund;
                        r_changeValid  <= 1'b1;
                        r_changeAmount <= w_refund;
                        r_state        <= S_CHANGE;
                    end else begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
`endif
                end
                S_CHANGE: begin
                    r_credit <= w_coin;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign itemIdx      = r_itemIdx;
    assign credit       = r_credit;
    assign dispenseReq  = r_dispenseReq;
    assign dispenseItem = r_dispenseItem;
    assign changeValid  = r_changeValid;
    assign changeAmount = r_changeAmount;
    assign denyFlag     = r_denyFlag;
    assign busy         = r_busy;

endmodule
